// File: rtl/inst_sequencer_if.sv
// Memory-read and processor-issue signals between the sequencer and the
// instruction memory / bus processor.
interface inst_sequencer_if #(
   parameter int AW = 5
);
   logic [AW-1:0] MemAddr;
   logic          MemRd;
   logic [15:0]   MemQ;
   logic [15:0]   DIN;
   logic          Run;
   logic          Done;

   modport master (
      output MemAddr, MemRd, DIN, Run,
      input  MemQ, Done
   );

   modport slave (
      input  MemAddr, MemRd, DIN, Run,
      output MemQ, Done
   );
endinterface

// File: rtl/inst_sequencer.sv
// Fetch/issue controller: reads an instruction at PC, issues it to the bus
// processor with a one-cycle Run strobe and waits for Done under a watchdog.
module inst_sequencer #(
   parameter int            AW       = 5,
   parameter logic [AW-1:0] RESET_PC = '0,
   parameter int            TMO      = 8
) (
   input  logic                    Clock,
   input  logic                    Resetn,
   input  logic                    Go,
   input  logic                    StepMode,
   input  logic                    Stop,
   inst_sequencer_if.master        bus,
   output logic [AW-1:0]           PC,
   output logic [15:0]             ICount,
   output logic                    Busy,
   output logic                    Halted,
   output logic                    Err
);

   localparam int WW = $clog2(TMO);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, ISSUE, EXEC, PAUSED, HALTED, ERROR
   } state_t;

   state_t         state, next_state;
   logic [15:0]    hold;
   logic [WW-1:0]  wd;
   logic           stop_req;
   logic           in_flight;

   assign in_flight = (state == FETCH) || (state == DECODE) ||
                      (state == ISSUE) || (state == EXEC);

   always_ff @(posedge Clock) begin
      if (!Resetn) state <= IDLE;
      else         state <= next_state;
   end

   // Done takes priority over the watchdog expiring in the same cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (Go) next_state = FETCH;
         FETCH:   next_state = DECODE;
         DECODE:  next_state = (bus.MemQ[15:13] == 3'b111) ? HALTED : ISSUE;
         ISSUE:   next_state = EXEC;
         EXEC: begin
            if (bus.Done)
               next_state = (StepMode || stop_req || Stop) ? PAUSED : FETCH;
            else if (wd == WW'(TMO - 1))
               next_state = ERROR;
         end
         PAUSED:  if (Go) next_state = FETCH;
         HALTED:  next_state = HALTED;
         ERROR:   next_state = ERROR;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.MemRd = 1'b0;
      bus.Run   = 1'b0;
      Busy      = 1'b0;
      Halted    = 1'b0;
      Err       = 1'b0;
      case (state)
         FETCH:   begin bus.MemRd = 1'b1; Busy = 1'b1; end
         DECODE:  Busy = 1'b1;
         ISSUE:   begin bus.Run = 1'b1; Busy = 1'b1; end
         EXEC:    Busy = 1'b1;
         HALTED:  Halted = 1'b1;
         ERROR:   Err = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         PC       <= RESET_PC;
         ICount   <= '0;
         hold     <= '0;
         wd       <= '0;
         stop_req <= 1'b0;
      end else begin
         if (state == DECODE) hold <= bus.MemQ;
         if (state == ISSUE) begin
            PC <= PC + AW'(1);
            wd <= '0;
         end
         if (state == EXEC) begin
            wd <= wd + WW'(1);
            if (bus.Done) ICount <= ICount + 16'd1;
         end
         // Entering PAUSED consumes the request, even if Stop is high again.
         if (next_state == PAUSED && state == EXEC) stop_req <= 1'b0;
         else if (Stop && in_flight)                stop_req <= 1'b1;
      end
   end

   assign bus.MemAddr = PC;
   assign bus.DIN     = hold;

endmodule

// File: tb/tb_inst_sequencer.sv
// Randomized bench for inst_sequencer: a transaction-level model predicts the
// issue times, issued words and end state of each Go-initiated run.
module tb_inst_sequencer;
   localparam int AW    = 5;
   localparam int TMO   = 8;
   localparam int DEPTH = 32;
   localparam int NLAT  = 64;

   logic          Clock  = 1'b0;
   logic          Resetn = 1'b0;
   logic          Go = 1'b0, StepMode = 1'b0, Stop = 1'b0;
   logic [AW-1:0] PC;
   logic [15:0]   ICount;
   logic          Busy, Halted, Err;

   inst_sequencer_if #(.AW(AW)) bus ();

   inst_sequencer #(.AW(AW), .RESET_PC('0), .TMO(TMO)) dut (
      .Clock(Clock), .Resetn(Resetn), .Go(Go), .StepMode(StepMode),
      .Stop(Stop), .bus(bus), .PC(PC), .ICount(ICount),
      .Busy(Busy), .Halted(Halted), .Err(Err)
   );

   always #5 Clock = ~Clock;

   int n_vec = 0, n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Synchronous memory and a processor whose completion latency is table-driven
   // (0 = never completes). The latency counter ignores reset on purpose.
   logic [15:0] mem [DEPTH];
   int          lat_tab [NLAT];
   int          cd = 0, proc_idx = 0, cyc = 0;

   always @(posedge Clock) begin
      cyc <= cyc + 1;
      if (bus.MemRd) bus.MemQ <= mem[bus.MemAddr];
      if (!Resetn) proc_idx <= 0;
      else if (bus.Run) proc_idx <= proc_idx + 1;
      if (bus.Run) cd <= lat_tab[proc_idx % NLAT];
      else if (cd > 0) cd <= cd - 1;
   end
   assign bus.Done = (cd == 1);

   int          run_cyc[$];
   logic [15:0] run_din[$];
   logic        prev_run = 1'b0;
   int          n_gap = 0;

   always @(negedge Clock) begin
      if (bus.Run) begin
         if (prev_run) n_gap++;
         run_cyc.push_back(cyc);
         run_din.push_back(bus.DIN);
      end
      prev_run = bus.Run;
   end

   // Model state: next PC, completed count, terminal status (0 none, 1 halted, 2 error).
   int m_pc, m_cnt, m_term, m_issue;

   task automatic do_reset();
      @(negedge Clock);
      Resetn = 1'b0; Go = 1'b0; Stop = 1'b0; StepMode = 1'b0;
      @(negedge Clock);
      Resetn = 1'b1;
      m_pc = 0; m_cnt = 0; m_term = 0; m_issue = 0;
      check("rst_pc", PC, 0);
      check("rst_icount", ICount, 0);
      check("rst_busy", Busy, 0);
      check("rst_halted", Halted, 0);
      check("rst_err", Err, 0);
      check("rst_run", bus.Run, 0);
      check("rst_memrd", bus.MemRd, 0);
      check("rst_din", bus.DIN, 0);
   endtask

   // One Go pulse; the model walks the program until pause, halt or timeout.
   task automatic segment(input bit step, input int stop_at);
      int g, t, L, ni, end_t, stop_t, base, cnt;
      int e_cyc[$];
      logic [15:0] e_din[$];
      logic [15:0] w;
      bit fin;
      @(negedge Clock);
      g = cyc; StepMode = step; base = run_cyc.size();
      t = g + 3; ni = 0; stop_t = -1; fin = 0; end_t = 0;
      while (!fin) begin
         w = mem[m_pc];
         if (w[15:13] == 3'b111) begin
            m_term = 1; end_t = t; fin = 1;
         end else begin
            e_cyc.push_back(t); e_din.push_back(w); ni++;
            if (ni == stop_at) stop_t = t - 2;
            L = lat_tab[m_issue % NLAT]; m_issue++;
            m_pc = (m_pc + 1) % DEPTH;
            if (L >= 1 && L <= TMO) begin
               m_cnt = (m_cnt + 1) % 65536;
               if (step || ni == stop_at) begin end_t = t + L + 1; fin = 1; end
               else t = t + L + 3;
            end else begin
               m_term = 2; end_t = t + TMO + 1; fin = 1;
            end
         end
      end
      Go = 1'b1;
      @(negedge Clock);
      Go = 1'b0;
      if (stop_t >= 0) begin
         while (cyc < stop_t) @(negedge Clock);
         Stop = 1'b1;
         @(negedge Clock);
         Stop = 1'b0;
      end
      while (cyc < end_t - 1) @(negedge Clock);
      check("busy_before_end", Busy, 1);
      @(negedge Clock);
      cnt = run_cyc.size() - base;
      check("n_issue", cnt, e_cyc.size());
      for (int i = 0; i < cnt && i < e_cyc.size(); i++) begin
         check("run_time", run_cyc[base + i] - g, e_cyc[i] - g);
         check("din", run_din[base + i], e_din[i]);
      end
      check("pc", PC, m_pc);
      check("icount", ICount, m_cnt);
      check("halted", Halted, m_term == 1);
      check("err", Err, m_term == 2);
      check("busy_end", Busy, 0);
      check("run_gap", n_gap, 0);
   endtask

   task automatic run_until_term(input bit step, input int stop_at);
      segment(step, stop_at);
      for (int s = 0; s < 40 && m_term == 0; s++) segment(step, 0);
   endtask

   task automatic terminal_ignores();
      int base;
      base = run_cyc.size();
      @(negedge Clock);
      Go = 1'b1; Stop = 1'b1;
      repeat (3) @(negedge Clock);
      Go = 1'b0; Stop = 1'b0;
      repeat (2) @(negedge Clock);
      check("term_err", Err, m_term == 2);
      check("term_halted", Halted, m_term == 1);
      check("term_busy", Busy, 0);
      check("term_no_run", run_cyc.size() - base, 0);
      check("term_pc", PC, m_pc);
      check("term_icount", ICount, m_cnt);
   endtask

   function automatic int rand_lat();
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) return 0;
      if (r == 1) return TMO + 3;
      if (r <= 3) return TMO;
      return $urandom_range(1, 4);
   endfunction

   task automatic load_demo();
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'h1001;
      mem[0] = 16'h1005; mem[1] = 16'h5003; mem[2] = 16'hE000;
      for (int i = 0; i < NLAT; i++) lat_tab[i] = 1;
      lat_tab[0] = 1; lat_tab[1] = 3;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int base, len;
      logic [15:0] w;
      bit step;
      int stop_at;
      bit seen;

      load_demo(); do_reset();
      run_until_term(1'b0, 0);
      terminal_ignores();

      load_demo(); do_reset();
      run_until_term(1'b1, 0);

      load_demo(); do_reset();
      run_until_term(1'b0, 1);

      load_demo(); lat_tab[0] = 0; do_reset();
      run_until_term(1'b0, 0);
      terminal_ignores();
      do_reset();

      load_demo(); lat_tab[0] = TMO; lat_tab[1] = TMO; do_reset();
      run_until_term(1'b0, 0);

      for (int i = 0; i < DEPTH; i++) mem[i] = 16'h1001;
      for (int i = 0; i < NLAT; i++) lat_tab[i] = (i % 7 == 3) ? TMO : 1;
      do_reset();
      segment(1'b0, 35);

      // Reset in the first EXEC cycle; the pending Done then lands in IDLE.
      load_demo(); lat_tab[0] = 5; do_reset();
      @(negedge Clock);
      Go = 1'b1;
      @(negedge Clock);
      Go = 1'b0;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (bus.Run) seen = 1;
         else @(negedge Clock);
      end
      check("rst_exec_run_seen", seen, 1);
      do_reset();
      base = run_cyc.size();
      repeat (8) @(negedge Clock);
      check("late_done_icount", ICount, 0);
      check("late_done_busy", Busy, 0);
      check("late_done_no_run", run_cyc.size() - base, 0);

      for (int it = 0; it < 40; it++) begin
         len = $urandom_range(1, 10);
         for (int i = 0; i < DEPTH; i++) begin
            w = 16'($urandom);
            if (w[15:13] == 3'b111) w[15] = 1'b0;
            mem[i] = w;
         end
         w = 16'($urandom);
         w[15:13] = 3'b111;
         mem[len] = w;
         for (int i = 0; i < NLAT; i++) lat_tab[i] = rand_lat();
         step = ($urandom_range(0, 3) == 0);
         stop_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
         do_reset();
         run_until_term(step, stop_at);
         if (m_term == 2) terminal_ignores();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
